// File: rtl/rom_sequencer.sv
// rom_sequencer -- steps a ROM address either one step per debounced button
// press (MANUAL mode) or automatically every RUN_PERIOD cycles (RUN mode).
// A small handshake FSM (IDLE -> SETTLE -> WAIT) waits for the ROM to present
// valid data after each address change. At most one step request is held
// pending while the sequencer is busy or the ROM is not ready.
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   reset      in   synchronous, active-high reset
//   btn_step   in   raw asynchronous step button, active-high
//   btn_mode   in   raw asynchronous mode button, active-high
//   rom_ready  in   level, instruction valid for the current address
//   address    out  current ROM address (registered)
//   running    out  1 = RUN mode, 0 = MANUAL mode
//   busy       out  1 while the FSM is not in IDLE
//   wrapped    out  one-cycle pulse when address wraps LAST_ADDRESS -> 0
module rom_sequencer #(
  parameter int ADDR_WIDTH      = 16,
  parameter int LAST_ADDRESS    = 2**ADDR_WIDTH-1,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int RUN_PERIOD      = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_step,
  input  logic                  btn_mode,
  input  logic                  rom_ready,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  running,
  output logic                  busy,
  output logic                  wrapped
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW  = $clog2(RUN_PERIOD + 1);

  localparam logic [ADDR_WIDTH-1:0] LAST_A    = ADDR_WIDTH'(LAST_ADDRESS);
  localparam logic [DBW-1:0]        DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0]         TICK_LAST = TW'(RUN_PERIOD - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;

  // Button index 0 = step, 1 = mode.
  localparam int unsigned B_STEP = 0;
  localparam int unsigned B_MODE = 1;

  logic [1:0]                sync1_q, sync2_q;
  logic [1:0]                level_q, level_d;
  logic [1:0]                press_q, press_d;
  logic [1:0][DBW-1:0]       cnt_q, cnt_d;

  logic                      running_q, running_d;
  logic [TW-1:0]             tick_q, tick_d;

  logic [1:0]                state_q, state_d;
  logic [ADDR_WIDTH-1:0]     address_q, address_d;
  logic                      pending_q, pending_d;
  logic                      wrapped_q, wrapped_d;

  logic                      run_tick;
  logic                      step_req;
  logic [ADDR_WIDTH-1:0]     next_addr;

  // Debounce: the level follows the synchronised input only after it has
  // disagreed for DEBOUNCE_CYCLES cycles in a row; a 0->1 flip emits a press.
  always_comb begin
    level_d = level_q;
    press_d = '0;
    cnt_d   = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          level_d[i] = sync2_q[i];
          press_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Mode and RUN tick. The tick counter is forced to 0 whenever the current
  // or next mode is MANUAL, so it restarts from 0 on every entry to RUN.
  always_comb begin
    running_d = running_q ^ press_q[B_MODE];
    if (!running_q || !running_d || (tick_q == TICK_LAST)) begin
      tick_d = '0;
    end else begin
      tick_d = tick_q + 1'b1;
    end
  end

  assign run_tick  = running_q && (tick_q == TICK_LAST);
  // Step presses are judged against the mode before any same-cycle toggle.
  assign step_req  = (press_q[B_STEP] && !running_q) || run_tick;
  assign next_addr = (address_q == LAST_A) ? '0 : address_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    address_d = address_q;
    pending_d = pending_q;
    wrapped_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((step_req || pending_q) && rom_ready) begin
          address_d = next_addr;
          wrapped_d = (address_q == LAST_A);
          pending_d = 1'b0;
          state_d   = S_SETTLE;
        end else if (step_req) begin
          pending_d = 1'b1;
        end
      end
      S_SETTLE: begin
        state_d = S_WAIT;
        if (step_req) pending_d = 1'b1;
      end
      S_WAIT: begin
        if (rom_ready) state_d = S_IDLE;
        if (step_req) pending_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      tick_q    <= '0;
      state_q   <= S_IDLE;
      address_q <= '0;
      pending_q <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      sync1_q   <= {btn_mode, btn_step};
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
      tick_q    <= tick_d;
      state_q   <= state_d;
      address_q <= address_d;
      pending_q <= pending_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign address = address_q;
  assign running = running_q;
  assign busy    = (state_q != S_IDLE);
  assign wrapped = wrapped_q;

endmodule

// File: tb/tb_rom_sequencer.sv
// Directed bench for rom_sequencer with ADDR_WIDTH=4, LAST_ADDRESS=5,
// DEBOUNCE_CYCLES=4, RUN_PERIOD=8. Inputs change and outputs are sampled
// 1 time unit after each rising clock edge.
module tb_rom_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_step;
  logic       btn_mode;
  logic       rom_ready;
  logic [3:0] address;
  logic       running;
  logic       busy;
  logic       wrapped;

  int n_checks = 0;
  int n_fail   = 0;

  rom_sequencer #(
    .ADDR_WIDTH      (4),
    .LAST_ADDRESS    (5),
    .DEBOUNCE_CYCLES (4),
    .RUN_PERIOD      (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_step  (btn_step),
    .btn_mode  (btn_mode),
    .rom_ready (rom_ready),
    .address   (address),
    .running   (running),
    .busy      (busy),
    .wrapped   (wrapped)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Press held 8 cycles, released 8 cycles; no checks.
  task automatic press_plain();
    btn_step = 1'b1;
    cyc(8);
    btn_step = 1'b0;
    cyc(8);
  endtask

  // Press: address changes on the 7th edge after the button goes high
  // (2 sync + 4 debounce + 1 press pulse).
  task automatic press_check(input logic [3:0] exp_addr, input logic exp_wrap);
    btn_step = 1'b1;
    cyc(7);
    check("press_addr", 32'(address), 32'(exp_addr));
    check("press_wrap", 32'(wrapped), 32'(exp_wrap));
    cyc(1);
    check("wrap_pulse_end", 32'(wrapped), 32'd0);
    btn_step = 1'b0;
    cyc(8);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    btn_step  = 1'b0;
    btn_mode  = 1'b0;
    rom_ready = 1'b1;
    cyc(3);
    check("rst_addr",    32'(address), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_wrapped", 32'(wrapped), 32'd0);
    reset = 1'b0;

    // Held press (10 cycles): exactly one step, busy for SETTLE and WAIT.
    btn_step = 1'b1;
    cyc(6);
    check("hold_pre_addr", 32'(address), 32'd0);
    check("hold_pre_busy", 32'(busy),    32'd0);
    cyc(1);
    check("hold_addr1",    32'(address), 32'd1);
    check("hold_settle",   32'(busy),    32'd1);
    cyc(1);
    check("hold_wait",     32'(busy),    32'd1);
    cyc(1);
    check("hold_idle",     32'(busy),    32'd0);
    cyc(1);
    btn_step = 1'b0;
    cyc(12);
    check("hold_one_step", 32'(address), 32'd1);

    // 3-cycle glitch stays below the debounce threshold.
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("glitch_rst_addr", 32'(address), 32'd0);
    btn_step = 1'b1;
    cyc(3);
    btn_step = 1'b0;
    cyc(12);
    check("glitch_addr", 32'(address), 32'd0);
    check("glitch_busy", 32'(busy),    32'd0);

    // Six clean presses: 1,2,3,4,5,0 with wrap only on 5->0.
    press_check(4'd1, 1'b0);
    press_check(4'd2, 1'b0);
    press_check(4'd3, 1'b0);
    press_check(4'd4, 1'b0);
    press_check(4'd5, 1'b0);
    press_check(4'd0, 1'b1);

    // Enter RUN: running rises 7 edges after the press; tick steps every 8.
    btn_mode = 1'b1;
    cyc(7);
    check("run_on",        32'(running), 32'd1);
    check("run_entry_addr",32'(address), 32'd0);
    btn_mode = 1'b0;
    cyc(7);
    check("run_before_tick", 32'(address), 32'd0);
    cyc(1);
    check("run_tick1",     32'(address), 32'd1);
    btn_step = 1'b1;
    cyc(7);
    check("run_step_ignored", 32'(address), 32'd1);
    cyc(1);
    check("run_tick2",     32'(address), 32'd2);
    btn_step = 1'b0;
    cyc(8);
    check("run_tick3",     32'(address), 32'd3);

    // Leave RUN: tick counter cleared, no further auto steps.
    btn_mode = 1'b1;
    cyc(7);
    check("run_off",       32'(running), 32'd0);
    check("run_off_addr",  32'(address), 32'd3);
    btn_mode = 1'b0;
    cyc(10);
    check("manual_hold_addr", 32'(address), 32'd3);
    check("manual_running",   32'(running), 32'd0);

    // Two presses while ROM not ready: a single pending step.
    rom_ready = 1'b0;
    press_plain();
    press_plain();
    check("notready_addr", 32'(address), 32'd3);
    check("notready_busy", 32'(busy),    32'd0);
    rom_ready = 1'b1;
    cyc(1);
    check("pending_addr",  32'(address), 32'd4);
    check("pending_busy",  32'(busy),    32'd1);
    cyc(2);
    check("pending_idle",  32'(busy),    32'd0);
    cyc(6);
    check("pending_once",  32'(address), 32'd4);

    // Reset while stuck in WAIT at address 3, with a mode press mid-debounce.
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    press_plain();
    press_plain();
    check("pre_wait_addr", 32'(address), 32'd2);
    btn_step = 1'b1;
    cyc(7);
    check("wait_addr3",    32'(address), 32'd3);
    rom_ready = 1'b0;
    btn_step  = 1'b0;
    cyc(2);
    check("in_wait_busy",  32'(busy),    32'd1);
    btn_mode = 1'b1;
    cyc(3);
    reset    = 1'b1;
    btn_mode = 1'b0;
    cyc(1);
    check("wrst_addr",     32'(address), 32'd0);
    check("wrst_busy",     32'(busy),    32'd0);
    check("wrst_running",  32'(running), 32'd0);
    check("wrst_wrapped",  32'(wrapped), 32'd0);
    reset     = 1'b0;
    rom_ready = 1'b1;
    cyc(12);
    check("post_rst_addr",    32'(address), 32'd0);
    check("post_rst_running", 32'(running), 32'd0);
    check("post_rst_busy",    32'(busy),    32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
